// File: rtl/exponent_job_arbiter_pkg.sv
// Shared state encoding, default operand widths and response codes for the
// exponent job arbiter.
package exponent_arb_pkg;

  localparam int X_W_DEF = 8;
  localparam int A_W_DEF = 8;
  localparam int P_W_DEF = 15;

  localparam logic RESP_OK      = 1'b0;
  localparam logic RESP_TIMEOUT = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Index that follows idx on a ring of n entries.
  function automatic int ring_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/exponent_job_arbiter_if.sv
// Requester, response and core handshake bundle of the exponent job arbiter.
// slave = arbiter view, master = surrounding requesters plus exponent core.
interface exponent_job_arbiter_if
  import exponent_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int X_W     = X_W_DEF,
  parameter int A_W     = A_W_DEF,
  parameter int P_W     = P_W_DEF
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ*X_W-1:0] req_x;
  logic [NUM_REQ*A_W-1:0] req_a;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ-1:0]     rsp_valid;
  logic [NUM_REQ-1:0]     rsp_ready;
  logic [P_W-1:0]         rsp_p;
  logic                   rsp_err;
  logic [X_W-1:0]         core_x;
  logic [A_W-1:0]         core_a;
  logic                   core_start;
  logic                   core_done;
  logic [P_W-1:0]         core_p;
  logic                   busy;
  logic [IDX_W-1:0]       grant_idx;
  logic [15:0]            job_cnt;

  modport slave (
    input  req_valid, req_x, req_a, rsp_ready, core_done, core_p,
    output req_ready, rsp_valid, rsp_p, rsp_err, core_x, core_a, core_start,
           busy, grant_idx, job_cnt
  );

  modport master (
    output req_valid, req_x, req_a, rsp_ready, core_done, core_p,
    input  req_ready, rsp_valid, rsp_p, rsp_err, core_x, core_a, core_start,
           busy, grant_idx, job_cnt
  );

endinterface

// File: rtl/exponent_job_arbiter_rr_priority_picker.sv
// Combinational rotating-priority encoder: first set request at or above
// rr_ptr (wrapping at NUM_REQ) wins.
module rr_priority_picker #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [$clog2(NUM_REQ)-1:0] win,
  output logic                       any_valid
);
  localparam int IDX_W = $clog2(NUM_REQ);

  assign any_valid = |req;

  // Walk from the farthest offset down so the nearest requester is written last.
  always_comb begin
    win = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      win = req[(int'(rr_ptr) + off) % NUM_REQ] ? IDX_W'((int'(rr_ptr) + off) % NUM_REQ) : win;
    end
  end

endmodule

// File: rtl/exponent_job_arbiter.sv
// Shares one exponent core between NUM_REQ requesters with rotating priority,
// one job in flight, result or timeout error routed back to the winner.
module exponent_job_arbiter
  import exponent_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int X_W         = X_W_DEF,
  parameter int A_W         = A_W_DEF,
  parameter int P_W         = P_W_DEF,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic                   S_AXI_ACLK,
  input logic                   S_AXI_ARESETN,
  exponent_job_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_t             state_r;
  logic [IDX_W-1:0]   rr_ptr_r;
  logic [IDX_W-1:0]   grant_idx_r;
  logic [IDX_W-1:0]   win_s;
  logic               any_valid_s;
  logic [NUM_REQ-1:0] req_ready_r;
  logic [NUM_REQ-1:0] rsp_valid_r;
  logic [X_W-1:0]     core_x_r;
  logic [A_W-1:0]     core_a_r;
  logic               core_start_r;
  logic [P_W-1:0]     rsp_p_r;
  logic               rsp_err_r;
  logic               busy_r;
  logic [15:0]        job_cnt_r;
  logic [CNT_W-1:0]   wait_cnt_r;
  logic               done_ok_s;
  logic               timeout_hit_s;
  logic               accept_s;

  rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req       (bus.req_valid),
    .rr_ptr    (rr_ptr_r),
    .win       (win_s),
    .any_valid (any_valid_s)
  );

  // The first WAIT cycle overlaps core_start, so a done seen then is left over from the previous job.
  assign done_ok_s     = bus.core_done && (wait_cnt_r != '0);
  assign timeout_hit_s = (wait_cnt_r == CNT_W'(TIMEOUT_CYC - 1));
  assign accept_s      = bus.rsp_ready[grant_idx_r];

  // Job sequencing: grant, issue, wait for done or timeout, hold response until accepted.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_r      <= IDLE;
      rr_ptr_r     <= '0;
      grant_idx_r  <= '0;
      req_ready_r  <= '0;
      rsp_valid_r  <= '0;
      core_x_r     <= '0;
      core_a_r     <= '0;
      core_start_r <= 1'b0;
      rsp_p_r      <= '0;
      rsp_err_r    <= RESP_OK;
      busy_r       <= 1'b0;
      job_cnt_r    <= 16'd0;
      wait_cnt_r   <= '0;
    end else begin
      req_ready_r  <= '0;
      core_start_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (any_valid_s) begin
            grant_idx_r <= win_s;
            core_x_r    <= bus.req_x[int'(win_s)*X_W +: X_W];
            core_a_r    <= bus.req_a[int'(win_s)*A_W +: A_W];
            req_ready_r <= NUM_REQ'(1) << win_s;
            busy_r      <= 1'b1;
            state_r     <= ISSUE;
          end
        end
        ISSUE: begin
          core_start_r <= 1'b1;
          wait_cnt_r   <= '0;
          state_r      <= WAIT;
        end
        WAIT: begin
          if (done_ok_s) begin
            rsp_p_r     <= bus.core_p;
            rsp_err_r   <= RESP_OK;
            rsp_valid_r <= NUM_REQ'(1) << grant_idx_r;
            state_r     <= RESP;
          end else if (timeout_hit_s) begin
            rsp_p_r     <= '0;
            rsp_err_r   <= RESP_TIMEOUT;
            rsp_valid_r <= NUM_REQ'(1) << grant_idx_r;
            state_r     <= RESP;
          end else begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
          end
        end
        RESP: begin
          if (accept_s) begin
            rsp_valid_r <= '0;
            job_cnt_r   <= job_cnt_r + 16'd1;
            rr_ptr_r    <= IDX_W'(ring_next(int'(grant_idx_r), NUM_REQ));
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          rsp_valid_r <= '0;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_r;
  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_p      = rsp_p_r;
  assign bus.rsp_err    = rsp_err_r;
  assign bus.core_x     = core_x_r;
  assign bus.core_a     = core_a_r;
  assign bus.core_start = core_start_r;
  assign bus.busy       = busy_r;
  assign bus.grant_idx  = grant_idx_r;
  assign bus.job_cnt    = job_cnt_r;

endmodule

// File: tb/tb_exponent_job_arbiter.sv
// Directed and randomized bench for exponent_job_arbiter with a mock core and
// a rotating-priority / power reference model.
module tb_exponent_job_arbiter;

  logic clk;
  logic rst_n;
  logic mock_rst_n;

  exponent_job_arbiter_if #(.NUM_REQ(4), .X_W(8), .A_W(8), .P_W(15)) bus ();

  exponent_job_arbiter #(
    .NUM_REQ(4), .X_W(8), .A_W(8), .P_W(15), .TIMEOUT_CYC(16)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .bus           (bus)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  int n_cfg;
  bit never_done;
  int rem;
  logic [7:0] mx, ma;
  logic [7:0] ox [4];
  logic [7:0] oa [4];
  logic [3:0] late_mask;
  int ptr_m;
  int cnt_m;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // x^a truncated to 15 bits.
  function automatic logic [14:0] pow_ref(input int x, input int a);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < a; i++) r = (r * longint'(x)) % 32768;
    return 15'(r);
  endfunction

  // First valid requester at or after ptr going round the ring.
  function automatic int pick_ref(input logic [3:0] m, input int ptr);
    for (int k = 0; k < 4; k++) begin
      if (m[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  // Mock core: done N cycles after start, done cleared by start, result held.
  always @(posedge clk or negedge mock_rst_n) begin
    if (!mock_rst_n) begin
      bus.core_done <= 1'b0;
      bus.core_p    <= 15'd0;
      rem <= 0;
      mx  <= 8'd0;
      ma  <= 8'd0;
    end else if (bus.core_start) begin
      bus.core_done <= 1'b0;
      rem <= never_done ? 0 : n_cfg - 1;
      mx  <= bus.core_x;
      ma  <= bus.core_a;
    end else if (rem == 1) begin
      bus.core_done <= 1'b1;
      bus.core_p    <= pow_ref(int'(mx), int'(ma));
      rem <= 0;
    end else if (rem > 1) begin
      rem <= rem - 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt = total_cnt + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic set_ops(input int idx, input logic [7:0] x, input logic [7:0] a);
    bus.req_x[idx*8 +: 8] = x;
    bus.req_a[idx*8 +: 8] = a;
    ox[idx] = x;
    oa[idx] = a;
  endtask

  task automatic set_req(input int idx, input logic [7:0] x, input logic [7:0] a);
    set_ops(idx, x, a);
    bus.req_valid[idx] = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " req_ready"},  32'(bus.req_ready), 32'd0);
    check({tag, " rsp_valid"},  32'(bus.rsp_valid), 32'd0);
    check({tag, " rsp_p"},      32'(bus.rsp_p), 32'd0);
    check({tag, " rsp_err"},    32'(bus.rsp_err), 32'd0);
    check({tag, " core_x"},     32'(bus.core_x), 32'd0);
    check({tag, " core_a"},     32'(bus.core_a), 32'd0);
    check({tag, " core_start"}, 32'(bus.core_start), 32'd0);
    check({tag, " busy"},       32'(bus.busy), 32'd0);
    check({tag, " grant_idx"},  32'(bus.grant_idx), 32'd0);
    check({tag, " job_cnt"},    32'(bus.job_cnt), 32'd0);
  endtask

  // Async reset asserted between edges, outputs checked right away, model cleared.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero(tag);
    bus.req_valid = 4'b0000;
    bus.rsp_ready = 4'b0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ptr_m = 0;
    cnt_m = 0;
    @(negedge clk);
  endtask

  // Expect requester idx to be granted, then check issue, latency, response and accept.
  task automatic serve(input int idx, input int hold, input logic exp_err, input int exp_lat,
                       input string tag);
    int k;
    int extra;
    logic [3:0] oh;
    logic [14:0] exp_p;
    logic [14:0] first_p;
    oh = 4'b0001 << idx;
    exp_p = exp_err ? 15'd0 : pow_ref(int'(ox[idx]), int'(oa[idx]));
    k = 0;
    while (bus.req_ready == 4'b0000 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check({tag, " req_ready"}, 32'(bus.req_ready), 32'(oh));
    check({tag, " grant_idx"}, 32'(bus.grant_idx), 32'(idx));
    bus.req_valid = (bus.req_valid & ~oh) | late_mask;
    late_mask = 4'b0000;
    @(negedge clk);
    check({tag, " req_ready_pulse"}, 32'(bus.req_ready), 32'd0);
    check({tag, " core_start"}, 32'(bus.core_start), 32'd1);
    check({tag, " core_x"}, 32'(bus.core_x), 32'(ox[idx]));
    check({tag, " core_a"}, 32'(bus.core_a), 32'(oa[idx]));
    k = 0;
    extra = 0;
    while (bus.rsp_valid == 4'b0000 && k < 64) begin
      @(negedge clk);
      k++;
      if (bus.core_start || bus.req_ready != 4'b0000) extra++;
    end
    check({tag, " latency"}, 32'(k), 32'(exp_lat));
    check({tag, " extra_pulses"}, 32'(extra), 32'd0);
    first_p = bus.rsp_p;
    for (int h = 0; h < hold; h++) begin
      bus.rsp_ready = ~oh;
      @(negedge clk);
      check({tag, " hold rsp_valid"}, 32'(bus.rsp_valid), 32'(oh));
      check({tag, " hold rsp_p"}, 32'(bus.rsp_p), 32'(first_p));
      check({tag, " hold req_ready"}, 32'(bus.req_ready), 32'd0);
    end
    check({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'(oh));
    check({tag, " rsp_p"}, 32'(bus.rsp_p), 32'(exp_p));
    check({tag, " rsp_err"}, 32'(bus.rsp_err), 32'(exp_err));
    check({tag, " busy_resp"}, 32'(bus.busy), 32'd1);
    bus.rsp_ready = oh;
    @(negedge clk);
    bus.rsp_ready = 4'b0000;
    cnt_m = (cnt_m + 1) % 65536;
    ptr_m = (idx + 1) % 4;
    check({tag, " job_cnt"}, 32'(bus.job_cnt), 32'(cnt_m));
    check({tag, " rsp_valid_clr"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, " busy_idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] m;
    int n;
    int w;
    int k;
    rst_n = 1'b1;
    bus.req_valid = 4'b0000;
    bus.req_x = 32'd0;
    bus.req_a = 32'd0;
    bus.rsp_ready = 4'b0000;
    late_mask = 4'b0000;
    never_done = 1'b0;
    n_cfg = 5;
    for (int i = 0; i < 4; i++) begin
      ox[i] = 8'd0;
      oa[i] = 8'd0;
    end
    mock_rst_n = 1'b1;
    #1;
    mock_rst_n = 1'b0;
    #1;
    mock_rst_n = 1'b1;
    do_reset("reset");

    // Single job: 2^3 through requester 0.
    n_cfg = 5;
    set_req(0, 8'd2, 8'd3);
    serve(0, 0, 1'b0, 6, "t1");

    // All four together right after reset, then requesters 1 and 3.
    do_reset("reset2");
    n_cfg = 3;
    set_req(0, 8'd3, 8'd3);
    set_req(1, 8'd5, 8'd2);
    set_req(2, 8'd0, 8'd4);
    set_req(3, 8'd9, 8'd0);
    serve(0, 0, 1'b0, 4, "t2_0");
    serve(1, 0, 1'b0, 4, "t2_1");
    serve(2, 0, 1'b0, 4, "t2_2");
    serve(3, 0, 1'b0, 4, "t2_3");
    set_req(1, 8'd7, 8'd3);
    set_req(3, 8'd255, 8'd2);
    serve(1, 0, 1'b0, 4, "t2b_1");
    serve(3, 0, 1'b0, 4, "t2b_3");

    // Response back-pressure on requester 2 while requester 0 waits.
    n_cfg = 4;
    set_req(2, 8'd9, 8'd2);
    set_ops(0, 8'd6, 8'd3);
    late_mask = 4'b0001;
    serve(2, 10, 1'b0, 5, "t3");
    serve(0, 0, 1'b0, 5, "t3b");

    // Core never completes: timeout error after 16 WAIT cycles.
    never_done = 1'b1;
    set_req(1, 8'd4, 8'd4);
    serve(1, 0, 1'b1, 16, "t4");
    never_done = 1'b0;

    // Randomized batches against the rotating-priority model.
    for (int b = 0; b < 12; b++) begin
      m = 4'($urandom_range(1, 15));
      n = $urandom_range(2, 8);
      n_cfg = n;
      for (int i = 0; i < 4; i++) begin
        if (m[i]) set_req(i, 8'($urandom), 8'($urandom_range(0, 12)));
      end
      while (m != 4'b0000) begin
        w = pick_ref(m, ptr_m);
        serve(w, 0, 1'b0, n + 1, "rnd");
        m[w] = 1'b0;
      end
    end

    // Reset in the middle of WAIT discards the job.
    n_cfg = 10;
    set_req(1, 8'd5, 8'd2);
    k = 0;
    while (bus.req_ready == 4'b0000 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("t5 req_ready", 32'(bus.req_ready), 32'h2);
    bus.req_valid = 4'b0000;
    repeat (3) @(negedge clk);
    do_reset("t5 mid_wait");
    n_cfg = 4;
    set_req(3, 8'd7, 8'd2);
    serve(3, 0, 1'b0, 5, "t5_post");

    // Done still high from the last job; the fresh 3^2 must be returned.
    n_cfg = 3;
    set_req(0, 8'd3, 8'd2);
    serve(0, 0, 1'b0, 4, "t6");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
